// File: rtl/psram_pkg.sv
// Shared constants and capture state encoding for the PSRAM SPI read path.
package psram_pkg;

   // PSRAM command opcodes issued by the command engine
   localparam logic [7:0] CMD_READ    = 8'h03;
   localparam logic [7:0] CMD_WRITE   = 8'h02;
   localparam logic [7:0] CMD_RST_EN  = 8'h66;
   localparam logic [7:0] CMD_RST     = 8'h99;
   localparam logic [7:0] CMD_READ_ID = 8'h9F;

   // Expected read-ID bytes: manufacturer ID and known-good-die marker
   localparam logic [7:0] MFID_EXP = 8'h0D;
   localparam logic [7:0] KGD_EXP  = 8'h5D;

   // Command + 24-bit address bit times ahead of read data
   localparam int unsigned RD_SKIP_BITS = 32;

   // Capture sequencer states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SKIP  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } cap_state_e;

endpackage

// File: rtl/psram_rx_fifo.sv
// Small synchronous byte FIFO. A push into a full FIFO is dropped unless a
// pop happens in the same cycle; the head entry is presented from storage.
module psram_rx_fifo #(
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic       sys_clk,
   input  logic       sys_reset_n,
   input  logic       push,
   input  logic [7:0] push_data,
   input  logic       rd_ready,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   output logic       drop
);

   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          full;
   logic          pop;
   logic          accept;

   // Pop is resolved before push so a full FIFO can accept in a pop cycle
   always_comb begin
      full     = (count == FULL_CNT);
      rd_valid = (count != '0);
      pop      = rd_valid & rd_ready;
      accept   = push & (~full | pop);
      drop     = push & full & ~pop;
      rd_data  = mem[rd_ptr];
   end

   // Storage, pointers and occupancy
   always_ff @(posedge sys_clk or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (accept) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         case ({accept, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/psram_rx_capture.sv
// PSRAM read-data capture: skips command/address bit times, assembles bytes
// MSB-first from SO and queues them in psram_rx_fifo.
// Optional read-ID checking is enabled by defining PSRAM_RX_ID_CHECK_EN.
module psram_rx_capture
   import psram_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned LEN_W      = 8,
   parameter int unsigned SKIP_W     = 6
) (
   input  logic              sys_clk,
   input  logic              sys_reset_n,
   input  logic              ce_n,
   input  logic              so_in,
   input  logic              rx_start,
   input  logic [SKIP_W-1:0] rx_skip,
   input  logic [LEN_W-1:0]  rx_len,
   output logic [7:0]        rd_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic              busy,
   output logic              done,
   output logic              overflow,
   output logic              short_burst,
   input  logic              clr_status
`ifdef PSRAM_RX_ID_CHECK_EN
   ,
   input  logic              id_mode,
   output logic              id_ok,
   output logic              id_bad
`endif
);

   cap_state_e        state, state_nxt;
   logic [SKIP_W-1:0] skip_q;
   logic [LEN_W-1:0]  len_q;
   logic [SKIP_W-1:0] skip_cnt;
   logic [LEN_W-1:0]  byte_cnt;
   logic [2:0]        bit_cnt;
   logic [6:0]        shreg;
   logic              ce_n_q;
   logic              bit_time;
   logic              ce_rise;
   logic              push;
   logic [7:0]        push_data;
   logic              set_short;
   logic              drop;

   // Bit-time qualifiers and the byte completing this cycle
   always_comb begin
      bit_time  = ~ce_n;
      ce_rise   = ce_n & ~ce_n_q;
      push_data = {shreg, so_in};
   end

   // Next-state and per-cycle strobes
   always_comb begin
      state_nxt = state;
      push      = 1'b0;
      set_short = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (rx_start) begin
               if (rx_len == '0)       state_nxt = DONE;
               else if (rx_skip == '0) state_nxt = SHIFT;
               else                    state_nxt = SKIP;
            end
         end
         SKIP: begin
            if (ce_rise) begin
               set_short = 1'b1;
               state_nxt = DONE;
            end else if (bit_time && (skip_cnt + SKIP_W'(1)) == skip_q) begin
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (ce_rise) begin
               set_short = 1'b1;
               state_nxt = DONE;
            end else if (bit_time && bit_cnt == 3'd7) begin
               push = 1'b1;
               if ((byte_cnt + LEN_W'(1)) == len_q) state_nxt = DONE;
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge sys_clk or negedge sys_reset_n) begin
      if (!sys_reset_n) state <= IDLE;
      else              state <= state_nxt;
   end

   // Arming, skip/bit/byte counters and the shift register
   always_ff @(posedge sys_clk or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         skip_q   <= '0;
         len_q    <= '0;
         skip_cnt <= '0;
         byte_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         ce_n_q   <= 1'b1;
      end else begin
         ce_n_q <= ce_n;
         case (state)
            IDLE: begin
               if (rx_start) begin
                  skip_q   <= rx_skip;
                  len_q    <= rx_len;
                  skip_cnt <= '0;
                  byte_cnt <= '0;
                  bit_cnt  <= '0;
               end
            end
            SKIP: begin
               if (bit_time) skip_cnt <= skip_cnt + SKIP_W'(1);
            end
            SHIFT: begin
               if (bit_time) begin
                  shreg   <= push_data[6:0];
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) byte_cnt <= byte_cnt + LEN_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Sticky status; a set in the same cycle as clr_status wins
   always_ff @(posedge sys_clk or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         overflow    <= 1'b0;
         short_burst <= 1'b0;
      end else begin
         if (drop)            overflow <= 1'b1;
         else if (clr_status) overflow <= 1'b0;
         if (set_short)       short_burst <= 1'b1;
         else if (clr_status) short_burst <= 1'b0;
      end
   end

   always_comb busy = (state != IDLE);

   psram_rx_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .sys_clk     (sys_clk),
      .sys_reset_n (sys_reset_n),
      .push        (push),
      .push_data   (push_data),
      .rd_ready    (rd_ready),
      .rd_data     (rd_data),
      .rd_valid    (rd_valid),
      .drop        (drop)
   );

`ifdef PSRAM_RX_ID_CHECK_EN
   logic id_mode_q;
   logic id_m0;
   logic id_m1;

   // Compare the first two captured bytes against the expected ID and
   // report the verdict when the capture finishes
   always_ff @(posedge sys_clk or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         id_mode_q <= 1'b0;
         id_m0     <= 1'b0;
         id_m1     <= 1'b0;
         id_ok     <= 1'b0;
         id_bad    <= 1'b0;
      end else begin
         if (state == IDLE && rx_start) begin
            id_mode_q <= id_mode;
            id_m0     <= 1'b0;
            id_m1     <= 1'b0;
         end else if (push) begin
            if (byte_cnt == LEN_W'(0)) id_m0 <= (push_data == MFID_EXP);
            if (byte_cnt == LEN_W'(1)) id_m1 <= (push_data == KGD_EXP);
         end
         if (state == DONE && id_mode_q && id_m0 && id_m1 && byte_cnt >= LEN_W'(2))
            id_ok <= 1'b1;
         else if (clr_status)
            id_ok <= 1'b0;
         if (state == DONE && id_mode_q && !(id_m0 && id_m1 && byte_cnt >= LEN_W'(2)))
            id_bad <= 1'b1;
         else if (clr_status)
            id_bad <= 1'b0;
      end
   end
`else
   // Read-ID checking not built
`endif

endmodule

// File: tb/tb_psram_rx_capture.sv
// Directed bench for psram_rx_capture (default FIFO_DEPTH=4).
// ID-check vectors run when PSRAM_RX_ID_CHECK_EN is defined.
module tb_psram_rx_capture;
   import psram_pkg::*;

   logic       sys_clk = 1'b0;
   logic       sys_reset_n;
   logic       ce_n;
   logic       so_in;
   logic       rx_start;
   logic [5:0] rx_skip;
   logic [7:0] rx_len;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       rd_ready;
   logic       busy;
   logic       done;
   logic       overflow;
   logic       short_burst;
   logic       clr_status;
`ifdef PSRAM_RX_ID_CHECK_EN
   logic       id_mode;
   logic       id_ok;
   logic       id_bad;
`endif

   int checks    = 0;
   int failures  = 0;
   int done_seen = 0;

   always #5 sys_clk = ~sys_clk;

   psram_rx_capture #(
      .FIFO_DEPTH (4),
      .LEN_W      (8),
      .SKIP_W     (6)
   ) dut (
      .sys_clk     (sys_clk),
      .sys_reset_n (sys_reset_n),
      .ce_n        (ce_n),
      .so_in       (so_in),
      .rx_start    (rx_start),
      .rx_skip     (rx_skip),
      .rx_len      (rx_len),
      .rd_data     (rd_data),
      .rd_valid    (rd_valid),
      .rd_ready    (rd_ready),
      .busy        (busy),
      .done        (done),
      .overflow    (overflow),
      .short_burst (short_burst),
      .clr_status  (clr_status)
`ifdef PSRAM_RX_ID_CHECK_EN
      ,
      .id_mode     (id_mode),
      .id_ok       (id_ok),
      .id_bad      (id_bad)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge sys_clk);
      #1;
      if (done) done_seen++;
   endtask

   task automatic send_bit(input logic b);
      ce_n  = 1'b0;
      so_in = b;
      step();
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
   endtask

   task automatic skip_bits(input int n);
      for (int i = 0; i < n; i++) send_bit(1'b1);
   endtask

   task automatic idle_ce();
      ce_n  = 1'b1;
      so_in = 1'b0;
      step();
   endtask

   task automatic arm(input logic [5:0] skip, input logic [7:0] len);
      rx_start = 1'b1;
      rx_skip  = skip;
      rx_len   = len;
      step();
      rx_start = 1'b0;
   endtask

   task automatic pop_expect(input string tag, input logic [7:0] b);
      check({tag, "_valid"}, 32'(rd_valid), 32'd1);
      check({tag, "_data"}, 32'(rd_data), 32'(b));
      rd_ready = 1'b1;
      step();
      rd_ready = 1'b0;
   endtask

   task automatic pulse_clr();
      clr_status = 1'b1;
      step();
      clr_status = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   initial begin
      sys_reset_n = 1'b0;
      ce_n        = 1'b1;
      so_in       = 1'b0;
      rx_start    = 1'b0;
      rx_skip     = '0;
      rx_len      = '0;
      rd_ready    = 1'b0;
      clr_status  = 1'b0;
`ifdef PSRAM_RX_ID_CHECK_EN
      id_mode     = 1'b0;
`endif
      step();
      step();
      check("rst_valid", 32'(rd_valid), 32'd0);
      check("rst_data", 32'(rd_data), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      check("rst_short", 32'(short_burst), 32'd0);
      sys_reset_n = 1'b1;
      step();

      // Single byte 0x66 after 32 skipped bit times, consumer always ready
      rd_ready  = 1'b1;
      done_seen = 0;
      arm(6'(RD_SKIP_BITS), 8'd1);
      check("t1_busy", 32'(busy), 32'd1);
      skip_bits(32);
      check("t1_no_early", 32'(rd_valid), 32'd0);
      send_byte(8'h66);
      check("t1_valid", 32'(rd_valid), 32'd1);
      check("t1_data", 32'(rd_data), 32'h66);
      check("t1_done", 32'(done), 32'd1);
      idle_ce();
      check("t1_popped", 32'(rd_valid), 32'd0);
      check("t1_idle", 32'(busy), 32'd0);
      check("t1_done_cnt", 32'(done_seen), 32'd1);
      check("t1_ovf", 32'(overflow), 32'd0);
      check("t1_short", 32'(short_burst), 32'd0);

      // Four bytes fill the FIFO exactly, head held while not ready
      rd_ready = 1'b0;
      arm(6'd32, 8'd4);
      skip_bits(32);
      send_byte(8'hA5);
      send_byte(8'h3C);
      send_byte(8'hFF);
      send_byte(8'h00);
      check("t2_done", 32'(done), 32'd1);
      idle_ce();
      idle_ce();
      check("t2_hold", 32'(rd_data), 32'hA5);
      check("t2_ovf", 32'(overflow), 32'd0);
      pop_expect("t2_b0", 8'hA5);
      pop_expect("t2_b1", 8'h3C);
      pop_expect("t2_b2", 8'hFF);
      pop_expect("t2_b3", 8'h00);
      check("t2_empty", 32'(rd_valid), 32'd0);

      // Six bytes into four entries: last two dropped, overflow sticky
      arm(6'd32, 8'd6);
      skip_bits(32);
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      send_byte(8'h44);
      check("t3_no_ovf_yet", 32'(overflow), 32'd0);
      send_byte(8'h55);
      send_byte(8'h66);
      idle_ce();
      check("t3_ovf", 32'(overflow), 32'd1);
      pop_expect("t3_b0", 8'h11);
      pop_expect("t3_b1", 8'h22);
      pop_expect("t3_b2", 8'h33);
      pop_expect("t3_b3", 8'h44);
      check("t3_empty", 32'(rd_valid), 32'd0);
      check("t3_ovf_sticky", 32'(overflow), 32'd1);
      pulse_clr();
      check("t3_ovf_clr", 32'(overflow), 32'd0);

      // Push into a full FIFO in the same cycle as a pop: no drop
      arm(6'd32, 8'd5);
      skip_bits(32);
      send_byte(8'h01);
      send_byte(8'h02);
      send_byte(8'h03);
      send_byte(8'h04);
      send_bit(1'b0); send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
      send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
      rd_ready = 1'b1;
      send_bit(1'b1);
      rd_ready = 1'b0;
      check("t4_done", 32'(done), 32'd1);
      check("t4_ovf", 32'(overflow), 32'd0);
      idle_ce();
      pop_expect("t4_b1", 8'h02);
      pop_expect("t4_b2", 8'h03);
      pop_expect("t4_b3", 8'h04);
      pop_expect("t4_b4", 8'h05);
      check("t4_empty", 32'(rd_valid), 32'd0);

      // ce_n rises 12 bits into a 2-byte burst
      done_seen = 0;
      arm(6'd32, 8'd2);
      skip_bits(32);
      send_byte(8'h81);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
      idle_ce();
      check("t5_done", 32'(done), 32'd1);
      check("t5_short", 32'(short_burst), 32'd1);
      check("t5_valid", 32'(rd_valid), 32'd1);
      check("t5_data", 32'(rd_data), 32'h81);
      idle_ce();
      check("t5_idle", 32'(busy), 32'd0);
      check("t5_done_cnt", 32'(done_seen), 32'd1);
      pop_expect("t5_b0", 8'h81);
      check("t5_empty", 32'(rd_valid), 32'd0);
      pulse_clr();
      check("t5_short_clr", 32'(short_burst), 32'd0);

      // rx_len==0 completes at once; rx_start held into DONE is ignored
      rx_start = 1'b1;
      rx_skip  = 6'd5;
      rx_len   = 8'd0;
      step();
      check("t6_done", 32'(done), 32'd1);
      check("t6_busy", 32'(busy), 32'd1);
      step();
      rx_start = 1'b0;
      check("t6_ignored", 32'(busy), 32'd0);
      check("t6_done_low", 32'(done), 32'd0);
      check("t6_no_push", 32'(rd_valid), 32'd0);

      // rx_skip==0: first bit time is already data
      rd_ready = 1'b1;
      arm(6'd0, 8'd1);
      send_byte(8'hC3);
      check("t7_data", 32'(rd_data), 32'hC3);
      check("t7_done", 32'(done), 32'd1);
      idle_ce();
      check("t7_empty", 32'(rd_valid), 32'd0);

      // Asynchronous reset in the middle of the second byte
      rd_ready = 1'b0;
      arm(6'd32, 8'd2);
      skip_bits(32);
      send_byte(8'h77);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      check("t8_pre_valid", 32'(rd_valid), 32'd1);
      #2;
      sys_reset_n = 1'b0;
      #1;
      check("t8_rst_valid", 32'(rd_valid), 32'd0);
      check("t8_rst_data", 32'(rd_data), 32'd0);
      check("t8_rst_busy", 32'(busy), 32'd0);
      check("t8_rst_done", 32'(done), 32'd0);
      step();
      sys_reset_n = 1'b1;
      idle_ce();
      rd_ready = 1'b1;
      arm(6'd32, 8'd1);
      skip_bits(32);
      send_byte(8'h5A);
      check("t8_new_data", 32'(rd_data), 32'h5A);
      check("t8_new_done", 32'(done), 32'd1);
      idle_ce();

`ifdef PSRAM_RX_ID_CHECK_EN
      // Read ID returning the expected pair, then a bad KGD byte
      id_mode = 1'b1;
      arm(6'd32, 8'd2);
      id_mode = 1'b0;
      skip_bits(32);
      send_byte(8'h0D);
      send_byte(8'h5D);
      idle_ce();
      check("t9_id_ok", 32'(id_ok), 32'd1);
      check("t9_id_bad", 32'(id_bad), 32'd0);
      pulse_clr();
      check("t9_ok_clr", 32'(id_ok), 32'd0);
      id_mode = 1'b1;
      arm(6'd32, 8'd2);
      id_mode = 1'b0;
      skip_bits(32);
      send_byte(8'h0D);
      send_byte(8'h5C);
      idle_ce();
      check("t10_id_ok", 32'(id_ok), 32'd0);
      check("t10_id_bad", 32'(id_bad), 32'd1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
